param_fp_multiplier: RTL

//  Parametrised IEEE-754 binary multiplier; successor to the fixed single-precision multiplier.

---
 rtl/param_fp_multiplier.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/param_fp_multiplier.sv
// Parametrised IEEE-754 multiplier with independent stb/ack handshakes on both operands and the result.
// Define DENORM_EN for gradual underflow; the default build flushes subnormal inputs and results to zero.
module param_fp_multiplier #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [EXP_W+MAN_W:0]   input_a,
    input  logic                   input_a_stb,
    output logic                   input_a_ack,
    input  logic [EXP_W+MAN_W:0]   input_b,
    input  logic                   input_b_stb,
    output logic                   input_b_ack,
    output logic [EXP_W+MAN_W:0]   output_z,
    output logic                   output_z_stb,
    input  logic                   output_z_ack
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int M  = MAN_W + 1;
    localparam int P  = 2 * M;
    localparam int ES = EXP_W + 2;
    localparam logic signed [ES-1:0] BIAS    = ES'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [ES-1:0] EXP_MAX = ES'((1 << EXP_W) - 1);
    localparam logic signed [ES-1:0] ONE_E   = ES'(1);
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [3:0] {
        GET_A, GET_B, UNPACK, SPECIAL, MULTIPLY, NORMALISE, ROUND, PACK, PUT_Z
    } state_t;

    state_t state, state_next;

    logic [W-1:0]          a, b, z;
    logic [M-1:0]          a_man, b_man, man;
    logic signed [ES-1:0]  a_exp, b_exp, exp;
    logic                  sign;
    logic [P-1:0]          prod, p_al;
    logic signed [ES-1:0]  e_al;
    logic                  guard, rnd, sticky, inc;
    logic [M:0]            rsum;
    logic                  a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic                  special_hit;
    logic [W-1:0]          special_z;

    // Subnormal fields carry no hidden bit and sit at the same scale as exponent field 1.
    function automatic logic [M-1:0] sig_of(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
        return {|e, m};
    endfunction

    function automatic logic signed [ES-1:0] exp_of(input logic [EXP_W-1:0] e);
        return (|e) ? $signed({2'b00, e}) : ONE_E;
    endfunction

    assign a_nan = (&a[W-2 -: EXP_W]) && (|a[MAN_W-1:0]);
    assign b_nan = (&b[W-2 -: EXP_W]) && (|b[MAN_W-1:0]);
    assign a_inf = (&a[W-2 -: EXP_W]) && !(|a[MAN_W-1:0]);
    assign b_inf = (&b[W-2 -: EXP_W]) && !(|b[MAN_W-1:0]);
`ifdef DENORM_EN
    logic a_shift, b_shift;
    int   shift_i;
    logic lost;

    assign a_zero  = !(|a[W-2 -: EXP_W]) && !(|a[MAN_W-1:0]);
    assign b_zero  = !(|b[W-2 -: EXP_W]) && !(|b[MAN_W-1:0]);
    assign a_shift = (a_man != '0) && !a_man[M-1];
    assign b_shift = (b_man != '0) && !b_man[M-1];
`else
    assign a_zero = !(|a[W-2 -: EXP_W]);
    assign b_zero = !(|b[W-2 -: EXP_W]);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= GET_A;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            GET_A:     if (input_a_stb) state_next = GET_B;
            GET_B:     if (input_b_stb) state_next = UNPACK;
`ifdef DENORM_EN
            UNPACK:    if (!a_shift && !b_shift) state_next = SPECIAL;
`else
            UNPACK:    state_next = SPECIAL;
`endif
            SPECIAL:   state_next = special_hit ? PUT_Z : MULTIPLY;
            MULTIPLY:  state_next = NORMALISE;
            NORMALISE: state_next = ROUND;
            ROUND:     state_next = PACK;
            PACK:      state_next = PUT_Z;
            PUT_Z:     if (output_z_ack) state_next = GET_A;
            default:   state_next = GET_A;
        endcase
    end

    always_comb begin
        input_a_ack  = (state == GET_A);
        input_b_ack  = (state == GET_B);
        output_z_stb = (state == PUT_Z);
    end

    assign output_z = z;

    always_comb begin
        special_hit = 1'b1;
        special_z   = '0;
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf))
            special_z = QNAN;
        else if (a_inf || b_inf)
            special_z = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (a_zero || b_zero)
            special_z = {sign, {(W-1){1'b0}}};
        else
            special_hit = 1'b0;
    end

    // Align the hidden bit to the product MSB; subnormal results are shifted down with sticky kept.
    always_comb begin
        p_al = prod;
        e_al = exp;
        if (prod[P-1]) e_al = exp + ONE_E;
        else           p_al = prod << 1;
`ifdef DENORM_EN
        shift_i = 0;
        lost    = 1'b0;
        if (e_al[ES-1] || e_al == '0) begin
            shift_i = 1 - int'(e_al);
            if (shift_i >= P) begin
                lost = |p_al;
                p_al = '0;
            end else begin
                lost = |(p_al & ~({P{1'b1}} << shift_i));
                p_al = p_al >> shift_i;
            end
            p_al[0] = p_al[0] | lost;
            e_al    = '0;
        end
`endif
    end

    assign inc  = guard && (rnd || sticky || man[0]);
    assign rsum = {1'b0, man} + {{M{1'b0}}, inc};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a <= '0; b <= '0; z <= '0;
            a_man <= '0; b_man <= '0; man <= '0;
            a_exp <= '0; b_exp <= '0; exp <= '0;
            sign <= 1'b0; prod <= '0;
            guard <= 1'b0; rnd <= 1'b0; sticky <= 1'b0;
        end else begin
            case (state)
                GET_A: if (input_a_stb) begin
                    a     <= input_a;
                    a_man <= sig_of(input_a[W-2 -: EXP_W], input_a[MAN_W-1:0]);
                    a_exp <= exp_of(input_a[W-2 -: EXP_W]);
                end
                GET_B: if (input_b_stb) begin
                    b     <= input_b;
                    b_man <= sig_of(input_b[W-2 -: EXP_W], input_b[MAN_W-1:0]);
                    b_exp <= exp_of(input_b[W-2 -: EXP_W]);
                    sign  <= a[W-1] ^ input_b[W-1];
                end
`ifdef DENORM_EN
                UNPACK: begin
                    if (a_shift) begin
                        a_man <= a_man << 1;
                        a_exp <= a_exp - ONE_E;
                    end else if (b_shift) begin
                        b_man <= b_man << 1;
                        b_exp <= b_exp - ONE_E;
                    end
                end
`endif
                SPECIAL: if (special_hit) z <= special_z;
                MULTIPLY: begin
                    prod <= P'(a_man) * P'(b_man);
                    exp  <= a_exp + b_exp - BIAS;
                end
                NORMALISE: begin
                    man    <= p_al[P-1 -: M];
                    guard  <= p_al[M-1];
                    rnd    <= p_al[M-2];
                    sticky <= |p_al[M-3:0];
                    exp    <= e_al;
                end
                ROUND: begin
                    if (rsum[M]) begin
                        man <= rsum[M:1];
                        exp <= exp + ONE_E;
                    end else begin
                        man <= rsum[M-1:0];
`ifdef DENORM_EN
                        if (exp == '0 && rsum[M-1]) exp <= ONE_E;
`endif
                    end
                end
                PACK: begin
                    if (exp >= EXP_MAX)
                        z <= {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    else if (exp[ES-1] || exp == '0)
`ifdef DENORM_EN
                        z <= {sign, {EXP_W{1'b0}}, man[MAN_W-1:0]};
`else
                        z <= {sign, {(W-1){1'b0}}};
`endif
                    else
                        z <= {sign, exp[EXP_W-1:0], man[MAN_W-1:0]};
                end
                default: ;
            endcase
        end
    end
endmodule
